// File: rtl/accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accum_pkg
// Description : Shared types and helpers for the accum_bank accumulator bank.
//               - state_t   : sweep FSM states (RUN, CLEAR)
//               - calc_cw   : channel-index width, max(1, clog2(n))
//               - sat_max / sat_min : two's complement limits for a w-bit
//                 accumulator, returned 64 bits wide for slicing by callers
// Revision    : 1.0 - initial release
// ============================================================================
package accum_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Width of a channel index; a single channel still needs a 1-bit port.
  function automatic int calc_cw(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // Largest positive value of a w-bit two's complement number.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative value of a w-bit two's complement number (low w bits).
  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage : accum_pkg
`default_nettype wire

// File: rtl/accum_add_sat.sv
`default_nettype none
// ============================================================================
// Module      : accum_add_sat
// Description : Combinational signed add/subtract with overflow detection.
//               Optional macro ACCUM_SATURATE_EN: clamp the result to the
//               signed limits on overflow; otherwise the result wraps.
// Ports       : i_a    [ACC_W]  accumulator operand
//               i_b    [ACC_W]  sign-extended sample
//               i_sub           1: a - b, 0: a + b
//               o_sum  [ACC_W]  result (wrapped or clamped)
//               o_ovf           signed overflow of the ACC_W-bit result
// Revision    : 1.0 - initial release
// ============================================================================
module accum_add_sat
  import accum_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] i_a,
  input  logic [ACC_W-1:0] i_b,
  input  logic             i_sub,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf
);

  localparam logic [63:0]      c_max64   = sat_max(ACC_W);
  localparam logic [63:0]      c_min64   = sat_min(ACC_W);
  localparam logic [ACC_W-1:0] c_sat_max = c_max64[ACC_W-1:0];
  localparam logic [ACC_W-1:0] c_sat_min = c_min64[ACC_W-1:0];

  logic [ACC_W:0] w_a_ext;
  logic [ACC_W:0] w_b_ext;
  logic [ACC_W:0] w_res;

  always_comb begin
    w_a_ext = {i_a[ACC_W-1], i_a};
    w_b_ext = {i_b[ACC_W-1], i_b};
    w_res   = i_sub ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);
    // One guard bit: the true result fits in ACC_W bits only when the
    // guard bit matches the ACC_W-bit sign.
    o_ovf   = w_res[ACC_W] ^ w_res[ACC_W-1];
`ifdef ACCUM_SATURATE_EN
    // Guard bit carries the true sign of the unbounded result.
    if (o_ovf) begin
      o_sum = w_res[ACC_W] ? c_sat_min : c_sat_max;
    end else begin
      o_sum = w_res[ACC_W-1:0];
    end
`else
    o_sum = w_res[ACC_W-1:0];
`endif
  end

endmodule : accum_add_sat
`default_nettype wire

// File: rtl/accum_bank.sv
`default_nettype none
// ============================================================================
// Module      : accum_bank
// Description : Bank of CHANNELS independent signed ACC_W-bit accumulators
//               fed by a valid/ready sample port, with per-channel sticky
//               overflow flags, a registered read port and a clear-all sweep
//               that zeroes one channel per cycle.
//               Optional macro ACCUM_SATURATE_EN (in accum_add_sat): clamp
//               instead of wrap on overflow.
// Ports       : clk, rst                 clock, synchronous active-high reset
//               i_in_valid/o_in_ready    sample handshake (ready while RUN)
//               i_in_ch, i_in_data       target channel, signed sample
//               i_in_sub                 1: subtract, 0: add
//               i_clr_all, o_busy        start clear sweep / sweep running
//               i_rd_en, i_rd_ch         read request and channel
//               o_rd_valid, o_rd_data,   registered read response
//               o_rd_ovf
// Revision    : 1.0 - initial release
// ============================================================================
module accum_bank
  import accum_pkg::*;
#(
  parameter  int ACC_W    = 16,
  parameter  int IN_W     = 8,
  parameter  int CHANNELS = 4,
  localparam int CW       = calc_cw(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [CW-1:0]    i_in_ch,
  input  logic [IN_W-1:0]  i_in_data,
  input  logic             i_in_sub,
  input  logic             i_clr_all,
  output logic             o_busy,
  input  logic             i_rd_en,
  input  logic [CW-1:0]    i_rd_ch,
  output logic             o_rd_valid,
  output logic [ACC_W-1:0] o_rd_data,
  output logic             o_rd_ovf
);

  localparam logic [CW:0]   c_chan = (CW + 1)'(CHANNELS);
  localparam logic [CW-1:0] c_last = CW'(CHANNELS - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_idx;
  logic [ACC_W-1:0] r_acc [CHANNELS];
  logic [CHANNELS-1:0] r_ovf;

  logic             w_accept;
  logic             w_in_ok;
  logic             w_wr;
  logic             w_rd_ok;
  logic [ACC_W-1:0] w_a;
  logic [ACC_W-1:0] w_b;
  logic [ACC_W-1:0] w_sum;
  logic             w_add_ovf;

  assign o_in_ready = (r_state == ST_RUN);
  assign o_busy     = (r_state == ST_CLEAR);

  // Out-of-range channels are still handshaken, just never written.
  assign w_accept = i_in_valid & o_in_ready;
  assign w_in_ok  = ({1'b0, i_in_ch} < c_chan);
  assign w_wr     = w_accept & w_in_ok;
  assign w_rd_ok  = ({1'b0, i_rd_ch} < c_chan);

  assign w_a = w_in_ok ? r_acc[i_in_ch] : '0;
  assign w_b = ACC_W'(signed'(i_in_data));

  accum_add_sat #(
    .ACC_W (ACC_W)
  ) u_add (
    .i_a   (w_a),
    .i_b   (w_b),
    .i_sub (i_in_sub),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (i_clr_all) w_state_next = ST_CLEAR;
      ST_CLEAR: if (r_idx == c_last) w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  // FSM state and sweep index; idx rests at 0 so a sweep always starts there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_CLEAR && r_idx != c_last) begin
        r_idx <= r_idx + 1'b1;
      end else begin
        r_idx <= '0;
      end
    end
  end

  // Accumulator and flag arrays. Writes happen only in RUN and sweep clears
  // only in CLEAR, so a sample accepted alongside clr_all lands first and is
  // then wiped by the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_acc[c] <= '0;
      end
      r_ovf <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (r_state == ST_CLEAR && r_idx == CW'(c)) begin
          r_acc[c] <= '0;
          r_ovf[c] <= 1'b0;
        end else if (w_wr && i_in_ch == CW'(c)) begin
          r_acc[c] <= w_sum;
          r_ovf[c] <= r_ovf[c] | w_add_ovf;
        end
      end
    end
  end

  // Read stage samples pre-edge contents (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
      o_rd_ovf   <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        o_rd_data <= w_rd_ok ? r_acc[i_rd_ch] : '0;
        o_rd_ovf  <= w_rd_ok ? r_ovf[i_rd_ch] : 1'b0;
      end
    end
  end

endmodule : accum_bank
`default_nettype wire

// File: tb/tb_accum_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_bank
// Description : Self-checking bench for accum_bank (ACC_W=16, IN_W=8,
//               CHANNELS=4). A behavioural model of the bank predicts every
//               read response into a queue; a monitor pops and compares on
//               each rd_valid. Honours ACCUM_SATURATE_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_bank;

  localparam int ACC_W = 16;
  localparam int IN_W  = 8;
  localparam int CH    = 4;
  localparam int CW    = 2;

  localparam longint c_maxv = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint c_minv = -(longint'(1) << (ACC_W - 1));
  localparam longint c_modv = longint'(1) << ACC_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [CW-1:0]    in_ch = '0;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_sub = 1'b0;
  logic             clr_all = 1'b0;
  logic             busy;
  logic             rd_en = 1'b0;
  logic [CW-1:0]    rd_ch = '0;
  logic             rd_valid;
  logic [ACC_W-1:0] rd_data;
  logic             rd_ovf;

  always #5 clk = ~clk;

  accum_bank #(
    .ACC_W    (ACC_W),
    .IN_W     (IN_W),
    .CHANNELS (CH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_in_ch    (in_ch),
    .i_in_data  (in_data),
    .i_in_sub   (in_sub),
    .i_clr_all  (clr_all),
    .o_busy     (busy),
    .i_rd_en    (rd_en),
    .i_rd_ch    (rd_ch),
    .o_rd_valid (rd_valid),
    .o_rd_data  (rd_data),
    .o_rd_ovf   (rd_ovf)
  );

  // Reference state: plain integers, a countdown of remaining sweep cycles.
  longint           m_acc [CH];
  bit               m_ovf [CH];
  int               clr_left;
  logic [ACC_W:0]   exp_q [$];
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_apply(input int ch, input logic [IN_W-1:0] d, input bit sub);
    longint s;
    longint r;
    s = longint'(signed'(d));
    r = sub ? (m_acc[ch] - s) : (m_acc[ch] + s);
    if (r > c_maxv || r < c_minv) begin
      m_ovf[ch] = 1'b1;
`ifdef ACCUM_SATURATE_EN
      r = (r > c_maxv) ? c_maxv : c_minv;
`else
      r = r & (c_modv - 1);
      if (r > c_maxv) r = r - c_modv;
`endif
    end
    m_acc[ch] = r;
  endtask

  // One clock: check handshake status, predict read, advance model, clock.
  task automatic cycle();
    logic [63:0]      v;
    logic [ACC_W-1:0] d;
    chk("busy", 64'(busy), 64'(clr_left > 0));
    chk("in_ready", 64'(in_ready), 64'(clr_left == 0));
    if (rd_en) begin
      v = 64'(m_acc[int'(rd_ch)]);
      d = v[ACC_W-1:0];
      exp_q.push_back({d, m_ovf[int'(rd_ch)]});
    end
    if (clr_left > 0) begin
      m_acc[CH - clr_left] = 0;
      m_ovf[CH - clr_left] = 1'b0;
      clr_left--;
    end else begin
      if (in_valid) m_apply(int'(in_ch), in_data, in_sub);
      if (clr_all) clr_left = CH;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int ch, input int val, input bit sub);
    in_valid = 1'b1;
    in_ch    = CW'(ch);
    in_data  = IN_W'(val);
    in_sub   = sub;
    cycle();
    in_valid = 1'b0;
    in_sub   = 1'b0;
  endtask

  task automatic rd(input int ch);
    rd_en = 1'b1;
    rd_ch = CW'(ch);
    cycle();
    rd_en = 1'b0;
  endtask

  task automatic rd_all();
    for (int c = 0; c < CH; c++) rd(c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; clr_all = 1'b0; rd_en = 1'b0; in_sub = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < CH; c++) begin
      m_acc[c] = 0;
      m_ovf[c] = 1'b0;
    end
    clr_left = 0;
    exp_q.delete();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_ovf", 64'(rd_ovf), 64'd0);
  endtask

  // Monitor: every read response must match the oldest prediction.
  always @(negedge clk) begin : mon
    logic [ACC_W:0] e;
    if (!rst && rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", 64'(rd_data), 64'(e[ACC_W:1]));
        chk("rd_ovf", 64'(rd_ovf), 64'(e[0]));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr_left = 0;
    do_reset();

    // Repeated adds, plus reads of untouched channels.
    repeat (3) op(0, 5, 1'b0);
    rd_all();

    // Add then subtract past zero.
    op(1, 10, 1'b0);
    op(1, 25, 1'b1);
    rd(1);

    // Drive ch2 past the positive limit, then confirm the flag is sticky.
    repeat (259) op(2, 127, 1'b0);
    rd(2);
    op(2, -1, 1'b0);
    rd(2);

    // Clear sweep with a sample presented alongside clr_all and then held.
    op(3, 9, 1'b0);
    in_valid = 1'b1; in_ch = 2'd1; in_data = 8'd3; clr_all = 1'b1;
    cycle();
    clr_all = 1'b0;
    repeat (5) cycle();
    in_valid = 1'b0;
    rd_all();

    // Read-before-write on the same channel.
    op(3, 7, 1'b0);
    in_valid = 1'b1; in_ch = 2'd3; in_data = 8'd1;
    rd_en = 1'b1; rd_ch = 2'd3;
    cycle();
    in_valid = 1'b0; rd_en = 1'b0;
    rd(3);

    // Reads during a sweep, then reset in its second cycle.
    op(0, 40, 1'b0);
    op(2, 50, 1'b1);
    clr_all = 1'b1; rd_en = 1'b1; rd_ch = 2'd0;
    cycle();
    clr_all = 1'b0; rd_ch = 2'd2;
    cycle();
    rd_en = 1'b0;
    do_reset();
    rd_all();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_ch    = CW'($urandom_range(0, CH - 1));
      in_data  = IN_W'($urandom);
      in_sub   = 1'($urandom_range(0, 1));
      clr_all  = ($urandom_range(0, 49) == 0);
      rd_en    = 1'($urandom_range(0, 1));
      rd_ch    = CW'($urandom_range(0, CH - 1));
      cycle();
    end
    in_valid = 1'b0; clr_all = 1'b0; rd_en = 1'b0;
    idle(CH + 1);
    rd_all();
    idle(3);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_accum_bank
`default_nettype wire
